// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Target-side data memory for the core load/store port.
//                One request at a time over valid/ready, RV32I byte/half/word
//                lanes with sign/zero extension, a fixed configurable access
//                latency, and a registered response carrying data + error.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    // BASE_ADDR is expected word aligned; range checks work on word addresses.
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        commit;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait cycles the access commits on the accepting edge, so the
    // decode must look at the live request while idle.
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_f3;

    assign acc_we    = (state_q == S_IDLE) ? req_we     : we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    assign acc_f3    = (state_q == S_IDLE) ? req_funct3 : funct3_q;

    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             range_bad;
    logic             f3_bad;
    logic             align_bad;
    logic             acc_err;
    logic [31:0]      cur_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_val;
    logic [3:0]       be;
    logic [31:0]      wd_rep;
    logic [31:0]      wr_word;

    // Decode the access: error classification, load extraction, store merge.
    always_comb begin
        lane      = acc_addr[1:0];
        word_off  = acc_addr[31:2] - BASE_WORD;
        range_bad = (acc_addr[31:2] < BASE_WORD) ||
                    ({2'b00, word_off} >= 32'(DEPTH_WORDS));
        idx       = word_off[IDX_W-1:0];

        if (acc_we) begin
            f3_bad = acc_f3[2] || (acc_f3[1:0] == 2'b11);
        end else begin
            f3_bad = (acc_f3[1:0] == 2'b11) || (acc_f3 == 3'b110);
        end

        align_bad = ((acc_f3[1:0] == 2'b01) && lane[0]) ||
                    ((acc_f3[1:0] == 2'b10) && (lane != 2'b00));
        acc_err   = range_bad || f3_bad || align_bad;

        cur_word  = range_bad ? 32'h0 : mem[idx];
        ld_byte   = cur_word[{lane, 3'b000} +: 8];
        ld_half   = cur_word[{lane[1], 4'b0000} +: 16];

        // funct3[2] selects zero extension for LBU/LHU.
        case (acc_f3[1:0])
            2'b00:   ld_val = {{24{ld_byte[7] & ~acc_f3[2]}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~acc_f3[2]}}, ld_half};
            default: ld_val = cur_word;
        endcase

        case (acc_f3[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << lane;
                wd_rep = {2{acc_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = acc_wdata;
            end
        endcase

        wr_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = wd_rep[8*i +: 8];
            end
        end
    end

    // Next-state, handshake outputs and response capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        commit    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'h0 : ld_val;
        end
    end

    // Control and response registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage update on the committing edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && commit && acc_we && !acc_err) begin
            mem[idx] <= wr_word;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder with a byte-array
//                reference model and randomized load/store traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          DEPTH   = 256;
    localparam int          WAITC   = 2;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          EXP_LAT = 1 + WAITC;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_ready  = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mb [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Reference model: memory as a plain byte array, loads assembled and
    // sign-extended arithmetically.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic er);
        int     size;
        bit     sgn;
        longint v;
        longint off;
        size = 1;
        sgn  = 1'b0;
        er   = 1'b0;
        rd   = 32'h0;
        case ({we, f3})
            4'b1_000: size = 1;
            4'b1_001: size = 2;
            4'b1_010: size = 4;
            4'b0_000: begin size = 1; sgn = 1'b1; end
            4'b0_100: size = 1;
            4'b0_001: begin size = 2; sgn = 1'b1; end
            4'b0_101: size = 2;
            4'b0_010: size = 4;
            default:  er = 1'b1;
        endcase
        off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
        if ((int'(addr[1:0]) % size) != 0) er = 1'b1;
        if (off < 0 || (off / 4) >= DEPTH) er = 1'b1;
        if (er) return;
        if (we) begin
            for (int k = 0; k < size; k++) mb[int'(off) + k] = 8'(wdata >> (8 * k));
        end else begin
            v = 0;
            for (int k = 0; k < size; k++)
                v = v + longint'(mb[int'(off) + k]) * (longint'(1) << (8 * k));
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            rd = v[31:0];
        end
    endfunction

    // Issue one request, wait for the response, hold it `hold` cycles, then accept.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd  = 32'h0;
        er  = 1'bx;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid === 1'b1) begin
            rd = rsp_rdata;
            er = rsp_err;
            repeat (hold) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b vld=%b err=%b rd=%h expected 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b err=%b rd=%h expected 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL sw_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL sw_resp: got err=%b rd=%h expected 0 00000000", er, rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL lw_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL lw_resp: got err=%b rd=%h expected 0 deadbeef", er, rd);
        end
    endtask

    task automatic test_lanes();
        logic        t_we [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_ad [7]  = '{32'h13, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10};
        logic [2:0]  t_f3 [7]  = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b001};
        logic [31:0] t_ex [7]  = '{32'h0, 32'hFFFFFFA5, 32'h000000A5, 32'hA5ADBEEF,
                                   32'hFFFFA5AD, 32'h0000A5AD, 32'hFFFFBEEF};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 7; i++) begin
            do_req(t_we[i], t_ad[i], 32'h000000A5, t_f3[i], 0, rd, er, lat);
            n_checks++;
            if ({er, rd} !== {1'b0, t_ex[i]}) begin
                n_fail++;
                $display("FAIL lanes[%0d]: got err=%b rd=%h expected 0 %h", i, er, rd, t_ex[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        t_we [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_ad [9] = '{32'h11, 32'h10, 32'h400, 32'h10, 32'h11, 32'h13, 32'h10, 32'h3FC, 32'h3FC};
        logic [2:0]  t_f3 [9] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010};
        logic        t_ee [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_ex [9] = '{32'h0, 32'hA5ADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 9; i++) begin
            do_req(t_we[i], t_ad[i], 32'h12345678, t_f3[i], 0, rd, er, lat);
            n_checks++;
            if ({er, rd} !== {t_ee[i], t_ex[i]}) begin
                n_fail++;
                $display("FAIL errors[%0d]: got err=%b rd=%h expected %b %h", i, er, rd, t_ee[i], t_ex[i]);
            end
        end
        // Erroring stores above must not have touched word 0x10.
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hA5ADBEEF}) begin
            n_fail++;
            $display("FAIL errors_nowrite: got err=%b rd=%h expected 0 a5adbeef", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit spurious;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ready: got %b expected 0", req_ready);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
            n_checks++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hA5ADBEEF}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b err=%b rd=%h expected 1 0 0 a5adbeef",
                         c, rsp_valid, req_ready, rsp_err, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
        spurious = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) spurious = 1'b1; end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL bp_spurious: got rsp_valid=1 expected 0");
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hA5ADBEEF}) begin
            n_fail++;
            $display("FAIL bp_dropped_store: got err=%b rd=%h expected 0 a5adbeef", er, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit spurious;
        do_req(1'b1, 32'h20, 32'h11111111, 3'b010, 0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rm_first_sw: got err=%b rd=%h expected 0 00000000", er, rd);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rm_in_reset: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) spurious = 1'b1; end
        n_checks++;
        if (spurious || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_after_reset: got spurious=%b rdy=%b expected 0 1", spurious, req_ready);
        end
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h11111111}) begin
            n_fail++;
            $display("FAIL rm_persist: got err=%b rd=%h expected 0 11111111", er, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic er, eer, we; logic [2:0] f3; int lat;
        for (int w = 0; w < 16; w++) begin
            wdata = $urandom;
            do_req(1'b1, 32'(w * 4), wdata, 3'b010, 0, rd, er, lat);
            model(1'b1, 32'(w * 4), wdata, 3'b010, erd, eer);
            n_checks++;
            if ({er, rd} !== {eer, erd}) begin
                n_fail++;
                $display("FAIL preload[%0d]: got err=%b rd=%h expected %b %h", w, er, rd, eer, erd);
            end
        end
        for (int i = 0; i < 80; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            if ($urandom_range(0, 9) == 0) addr = 32'h400 + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, 63));
            do_req(we, addr, wdata, f3, $urandom_range(0, 3), rd, er, lat);
            model(we, addr, wdata, f3, erd, eer);
            n_checks++;
            if ({er, rd} !== {eer, erd} || lat !== EXP_LAT) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b a=%h f3=%b: got err=%b rd=%h lat=%0d expected %b %h %0d",
                         i, we, addr, f3, er, rd, lat, eer, erd, EXP_LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: abort if the sequence above never completes.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
